// File: rtl/spi_adc_scanner_if.sv
// Bundle for the serial-ADC scanner: trigger/config inputs, SPI pins and result outputs.
// The master side is the time base / ADC / consumer; the slave side is the scanner.
interface spi_adc_scanner_if #(
    parameter int N_CH   = 8,
    parameter int CH_W   = 3,
    parameter int DATA_W = 12
);
    logic                     trig;
    logic [N_CH-1:0]          ch_mask;
    logic                     scan_up;
    logic                     ovr_clr;
    logic                     miso;
    logic                     cs_l;
    logic                     sclk;
    logic                     mosi;
    logic                     busy;
    logic                     res_valid;
    logic [DATA_W-1:0]        res_data;
    logic [CH_W-1:0]          res_ch;
    logic [N_CH*DATA_W-1:0]   bank;
    logic                     ovr;

    modport master (
        output trig, ch_mask, scan_up, ovr_clr, miso,
        input  cs_l, sclk, mosi, busy, res_valid, res_data, res_ch, bank, ovr
    );

    modport slave (
        input  trig, ch_mask, scan_up, ovr_clr, miso,
        output cs_l, sclk, mosi, busy, res_valid, res_data, res_ch, bank, ovr
    );
endinterface

// File: rtl/spi_adc_scanner.sv
// Triggered serial-ADC channel scanner with a per-channel result bank.
// Optional sticky overrun flag: define SPI_ADC_SCANNER_OVERRUN_EN.
module spi_adc_scanner #(
    parameter int N_CH      = 8,
    parameter int CH_W      = 3,
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int ADDR_POS  = 2,
    parameter int TPB       = 4
) (
    input  logic               clk,
    input  logic               ares,
    spi_adc_scanner_if.slave   bus
);
    localparam int F      = LEAD_BITS + DATA_W;
    localparam int BIT_W  = (F > 1) ? $clog2(F) : 1;
    localparam int TICK_W = $clog2(TPB);

    typedef enum logic [1:0] {IDLE, FRAME, DONE} state_e;

    state_e                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [CH_W-1:0]         ch_cur_q, ch_cur_d;
    logic [CH_W-1:0]         ch_nxt_q, ch_nxt_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]       res_data_q, res_data_d;
    logic [CH_W-1:0]         res_ch_q, res_ch_d;
    logic [N_CH*DATA_W-1:0]  bank_q, bank_d;
    logic [CH_W-1:0]         scan_ch;
    logic                    cs_l, sclk, mosi;

    // The address sent now selects the channel converted in the *next* frame.
    always_comb begin
        int  idx;
        logic found;
        scan_ch = ch_cur_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = bus.scan_up ? (int'(ch_cur_q) + i) % N_CH
                              : (int'(ch_cur_q) - i + N_CH) % N_CH;
            if (!found && bus.ch_mask[CH_W'(idx)]) begin
                scan_ch = CH_W'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        ch_cur_d   = ch_cur_q;
        ch_nxt_d   = ch_nxt_q;
        shift_d    = shift_q;
        res_data_d = res_data_q;
        res_ch_d   = res_ch_q;
        bank_d     = bank_q;
        case (state_q)
            IDLE: begin
                if (bus.trig && (bus.ch_mask != '0)) begin
                    state_d  = FRAME;
                    tick_d   = '0;
                    bit_d    = '0;
                    ch_nxt_d = scan_ch;
                end
            end
            FRAME: begin
                if (tick_q == TICK_W'(TPB / 2))
                    shift_d = {shift_q[DATA_W-2:0], bus.miso};
                if (tick_q == TICK_W'(TPB - 1)) begin
                    tick_d = '0;
                    if (bit_q == BIT_W'(F - 1)) begin
                        // Publish on the way out so results are visible in the DONE cycle.
                        state_d    = DONE;
                        bit_d      = '0;
                        res_data_d = shift_d;
                        res_ch_d   = ch_cur_q;
                        bank_d[ch_cur_q*DATA_W +: DATA_W] = shift_d;
                        ch_cur_d   = ch_nxt_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ares) begin
        if (ares) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            ch_cur_q   <= '0;
            ch_nxt_q   <= '0;
            shift_q    <= '0;
            res_data_q <= '0;
            res_ch_q   <= '0;
            bank_q     <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            ch_cur_q   <= ch_cur_d;
            ch_nxt_q   <= ch_nxt_d;
            shift_q    <= shift_d;
            res_data_q <= res_data_d;
            res_ch_q   <= res_ch_d;
            bank_q     <= bank_d;
        end
    end

    always_comb begin
        cs_l = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        if (state_q == FRAME) begin
            cs_l = 1'b0;
            sclk = (tick_q >= TICK_W'(TPB / 2));
            for (int j = 0; j < CH_W; j++)
                if (bit_q == BIT_W'(ADDR_POS + j))
                    mosi = ch_nxt_q[CH_W-1-j];
        end
    end

    assign bus.cs_l      = cs_l;
    assign bus.sclk      = sclk;
    assign bus.mosi      = mosi;
    assign bus.busy      = (state_q == FRAME);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.bank      = bank_q;

`ifdef SPI_ADC_SCANNER_OVERRUN_EN
    logic ovr_q, ovr_d;

    // A set event beats a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        if (bus.trig && (state_q != IDLE))
            ovr_d = 1'b1;
        else if (bus.ovr_clr)
            ovr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge ares) begin
        if (ares) ovr_q <= 1'b0;
        else      ovr_q <= ovr_d;
    end

    assign bus.ovr = ovr_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = bus.ovr_clr;
    assign bus.ovr        = 1'b0;
`endif
endmodule

// File: doc/spi_adc_scanner.md
# spi_adc_scanner

Parametrised successor to the fixed 8-channel, 12-bit serial ADC front end. The block runs a serial-ADC conversion frame on each trigger pulse and scans channels up or down, skipping channels disabled by a mask. It tags each result with the channel that was actually converted, accounting for the one-frame address pipeline of ADC128S102-class parts. It keeps a per-channel result bank and sits between the sample-rate time base and the signal-processing chain.

## Interface
- N_CH, 8: channel count, 2..16
- CH_W, 3: channel index width, ceil(log2(N_CH))
- DATA_W, 12: conversion result width
- LEAD_BITS, 4: leading bits returned before the result MSB; these are discarded
- ADDR_POS, 2: frame bit index (0 = first bit) at which the channel address MSB is driven
- TPB, 4: clk ticks per serial bit; even, ≥2
- clk  in  1  system clock
- ares  in  1  asynchronous active-high reset
- trig  in  1  one-cycle frame start pulse (96 kHz time base)
- ch_mask  in  N_CH  channel enable; bit i set = channel i in scan
- scan_up  in  1  1 = ascending scan, 0 = descending
- ovr_clr  in  1  clears sticky overrun
- miso  in  1  ADC serial data return
- cs_l  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock, idles high
- mosi  out  1  ADC serial data send
- busy  out  1  frame in progress
- res_valid  out  1  one-cycle strobe: new result
- res_data  out  DATA_W  latest result
- res_ch  out  CH_W  channel of res_data
- bank  out  N_CH*DATA_W  per-channel results; channel i at [i*DATA_W +: DATA_W]
- ovr  out  1  sticky overrun flag

## Operation
- FSM states:
  - IDLE: cs_l=1, sclk=1, mosi=0. Waits for trig with ch_mask≠0. trig with ch_mask=0 is ignored.
  - FRAME: runs F = LEAD_BITS+DATA_W bits of TPB ticks each.
  - DONE: one cycle; publishes the result and returns to IDLE.
- Channel pipeline:
  - ch_cur is the channel being converted in this frame; it resets to 0, the part's power-up channel.
  - On entry to FRAME, ch_nxt latches the next enabled channel after ch_cur in the scan_up direction, with modulo N_CH wrap.
  - If only ch_cur is enabled, ch_nxt = ch_cur.
  - ch_nxt is driven MSB-first on mosi over bits ADDR_POS..ADDR_POS+CH_W-1. All other bits drive 0.
- Receive:
  - DATA_W-bit shift register, LSB-in.
  - Shifts miso on every sclk rising edge.
  - The LEAD_BITS leading bits fall out of the top, leaving the final DATA_W bits.
- DONE:
  - res_data ← shift register; res_ch ← ch_cur; bank slot ch_cur ← shift register.
  - res_valid=1; ch_cur ← ch_nxt.
  - A result for a channel with a cleared mask bit (for example the first frame, channel 0) is still published and banked.
- ch_mask and scan_up are sampled only on entry to FRAME. Changes mid-frame have no effect until the next frame.

## Timing
- trig seen at cycle T:
  - cs_l falls and busy rises at T+1.
  - Frame occupies cycles T+1 .. T+F·TPB.
  - DONE at T+F·TPB+1: cs_l=1, busy=0, res_valid=1, res_data/res_ch/bank updated in the same cycle.
  - Total latency trig→res_valid = F·TPB+1 cycles (65 at defaults).
- Each bit, starting at tick k=0 of TPB:
  - mosi updates at k=0.
  - sclk is low for k<TPB/2 and high for k≥TPB/2.
  - miso is sampled on the cycle sclk goes high.
- trig during FRAME or DONE:
  - Ignored; the frame is not restarted.
  - ovr set (see Configuration).
  - ovr_clr and a set event in the same cycle: set wins.
- Reset values:
  - cs_l=1, sclk=1, mosi=0, busy=0, res_valid=0, ovr=0.
  - res_data=0, res_ch=0, bank all 0.
  - ch_cur=0, ch_nxt=0, FSM=IDLE.
- ares asserted mid-frame aborts immediately with reset values; no partial result is published.

## Configuration
- SPI_ADC_SCANNER_OVERRUN_EN:
  - Defined: ovr is a sticky flag, set by an ignored trig and cleared by ovr_clr.
  - Undefined: ovr tied 0, ovr_clr unused, ignored triggers are silent.
  - Scan behaviour is identical in both cases.

## Test plan
- Defaults, mask=8'hFF, scan_up=0, miso model returns 4'b0 then 12'hA5C, trig every 512 cycles:
  - first res_ch=0, then 7, 6, … 0.
  - mosi address bits in frame 1 = 3'b111.
  - res_data=12'hA5C.
  - res_valid 65 cycles after each trig.
- mask=8'b0010_0100, scan_up=1: res_ch sequence 0, 2, 5, 2, 5; bank slots 0, 2 and 5 written, others remain 0.
- Timing check over 16 bits: cs_l low for exactly 64 cycles; sclk low 2 / high 2 ticks per bit; miso sampled only on sclk rising ticks.
- trig again 10 cycles into a frame:
  - frame unaltered, single res_valid, ovr=1 (macro defined).
  - ovr_clr → 0.
  - Without the macro, ovr stays 0.
- ares pulsed at cycle 30 of a frame: cs_l=1 immediately, no res_valid; next trig converts channel 0.
- mask=0 with trig: no frame, busy stays 0, cs_l stays 1.
